// File: rtl/axis_width_conv_wide_narrow.sv
// Wide-to-narrow AXI-style stream converter: each M-bit word is emitted as M/N
// N-bit beats, most-significant slice first, from a two-page ping-pong buffer.
module axis_width_conv_wide_narrow #(
    parameter int N = 8,
    parameter int M = 24
) (
    input  logic         clk,
    input  logic         rst,
    output logic         s_axis_tnext,
    input  logic [M-1:0] s_axis_tdata,
    input  logic         s_axis_tfirst,
    input  logic         s_axis_tvalid,
    input  logic         m_axis_tnext,
    output logic [N-1:0] m_axis_tdata,
    output logic         m_axis_tfirst,
    output logic         m_axis_tvalid,
    output logic [15:0]  beat_count
);

    localparam int KN = M / N;
    localparam int PW = (KN > 1) ? $clog2(KN) : 1;
    localparam logic [PW-1:0] RD_TOP = PW'(KN - 1);

    generate
        if ((M % N) != 0 || KN < 2) begin : g_bad_width
            $error("axis_width_conv_wide_narrow: M must be an integer multiple (>=2) of N");
        end
    endgenerate

    logic [M-1:0]  r_buf [0:1];
    logic          r_first [0:1];
    logic          r_wr_page;
    logic          r_wr_ext;
    logic          r_rd_page;
    logic          r_rd_ext;
    logic [PW-1:0] r_rd_ptr;
    logic [15:0]   r_beat_count;

    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [M-1:0]  w_word;
    logic [N-1:0]  w_slice;

    // Ext bits distinguish the two laps of the page pointers, so equal pages
    // mean either empty or full depending on whether the laps match.
    assign w_empty = (r_wr_ext == r_rd_ext) && (r_wr_page == r_rd_page);
    assign w_full  = (r_wr_ext != r_rd_ext) && (r_wr_page == r_rd_page);

    assign s_axis_tnext = rst && s_axis_tvalid && !w_full;
    assign w_wr_en      = s_axis_tnext;
    assign w_rd_en      = rst && m_axis_tnext && !w_empty;

    assign w_word = r_buf[r_rd_page];

    always_comb begin
        w_slice = '0;
        for (int i = 0; i < KN; i++) begin
            if (r_rd_ptr == PW'(i)) begin
                w_slice = w_word[i*N +: N];
            end
        end
    end

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_slice;
    assign m_axis_tfirst = r_first[r_rd_page] && (r_rd_ptr == RD_TOP);
    assign beat_count    = r_beat_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_first[0]   <= 1'b0;
            r_first[1]   <= 1'b0;
            r_wr_page    <= 1'b1;
            r_wr_ext     <= 1'b1;
            r_rd_page    <= 1'b1;
            r_rd_ext     <= 1'b1;
            r_rd_ptr     <= RD_TOP;
            r_beat_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_buf[r_wr_page]   <= s_axis_tdata;
                r_first[r_wr_page] <= s_axis_tfirst;
                r_wr_page          <= ~r_wr_page;
                if (r_wr_page) begin
                    r_wr_ext <= ~r_wr_ext;
                end
            end
            if (w_rd_en) begin
                r_beat_count <= r_beat_count + 16'd1;
                if (r_rd_ptr != '0) begin
                    r_rd_ptr <= r_rd_ptr - PW'(1);
                end else begin
                    // Last slice of the word: hand the page back to the writer.
                    r_rd_ptr  <= RD_TOP;
                    r_rd_page <= ~r_rd_page;
                    if (r_rd_page) begin
                        r_rd_ext <= ~r_rd_ext;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_width_conv_wide_narrow.sv
// Directed bench for axis_width_conv_wide_narrow (N=8, M=24): single word,
// streaming, backpressure, reset mid-word and 16-bit beat counter wrap.
module tb_axis_width_conv_wide_narrow;

    localparam int N = 8;
    localparam int M = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_axis_tnext;
    logic [M-1:0]  s_axis_tdata = '0;
    logic          s_axis_tfirst = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          m_axis_tnext = 1'b0;
    logic [N-1:0]  m_axis_tdata;
    logic          m_axis_tfirst;
    logic          m_axis_tvalid;
    logic [15:0]   beat_count;

    always #5 clk = ~clk;

    axis_width_conv_wide_narrow #(.N(N), .M(M)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tnext  (s_axis_tnext),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tfirst (s_axis_tfirst),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tnext  (m_axis_tnext),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tfirst (m_axis_tfirst),
        .m_axis_tvalid (m_axis_tvalid),
        .beat_count    (beat_count)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    int          first_beat = -1;
    int          last_beat = -1;
    int          data_err = 0;
    bit          quiet = 1'b0;
    bit          accepted = 1'b0;
    bit          acc_at [0:63];
    logic [8:0]  exp_q [$];
    logic [23:0] src_d [$];
    logic        src_f [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: drive the head of the source queue, judge both handshakes at
    // the falling edge, then let the rising edge commit them.
    task automatic step();
        logic [8:0] e;
        if (src_d.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_d[0];
            s_axis_tfirst = src_f[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
            s_axis_tfirst = 1'b0;
        end
        @(negedge clk);
        accepted = s_axis_tvalid && s_axis_tnext;
        if (accepted) begin
            exp_q.push_back({s_axis_tfirst, s_axis_tdata[23:16]});
            exp_q.push_back({1'b0, s_axis_tdata[15:8]});
            exp_q.push_back({1'b0, s_axis_tdata[7:0]});
            if (cyc < 64) acc_at[cyc] = 1'b1;
        end
        if (rst && m_axis_tvalid && m_axis_tnext) begin
            beats_seen++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                if (quiet) begin
                    if ({m_axis_tfirst, m_axis_tdata} !== e) data_err++;
                end else begin
                    chk("beat", 32'({m_axis_tfirst, m_axis_tdata}), 32'(e));
                end
            end
        end
        @(posedge clk);
        #1;
        if (accepted) begin
            void'(src_d.pop_front());
            void'(src_f.pop_front());
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        src_d.delete();
        src_f.delete();
        m_axis_tnext = 1'b0;
        step();
        step();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tfirst", 32'(m_axis_tfirst), 32'd0);
        chk("rst_count", 32'(beat_count), 32'd0);
        s_axis_tvalid = 1'b1;
        #1;
        chk("rst_snext", 32'(s_axis_tnext), 32'd0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        cyc = 0;
        beats_seen = 0;
        first_beat = -1;
        last_beat = -1;
        foreach (acc_at[i]) acc_at[i] = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((src_d.size() > 0 || exp_q.size() > 0) && k < budget) begin
            step();
            k++;
        end
        chk("idle_in_time", 32'(k < budget), 32'd1);
        chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        logic [7:0] pat;
        int         hold_err;
        int         acc_cnt;
        int         k;

        // Single word
        do_reset();
        m_axis_tnext = 1'b1;
        src_d.push_back(24'hA1B2C3); src_f.push_back(1'b1);
        run_until_idle(20);
        chk("t1_accept_pulse", 32'({acc_at[1], acc_at[0]}), 32'b01);
        chk("t1_latency", 32'(first_beat), 32'd1);
        chk("t1_beats", 32'(beats_seen), 32'd3);
        chk("t1_count", 32'(beat_count), 32'd3);

        // Streaming; cycle 3 is full with a last-slice read, so no accept there
        do_reset();
        m_axis_tnext = 1'b1;
        src_d.push_back(24'h010203); src_f.push_back(1'b1);
        src_d.push_back(24'h040506); src_f.push_back(1'b0);
        src_d.push_back(24'h070809); src_f.push_back(1'b0);
        src_d.push_back(24'h0A0B0C); src_f.push_back(1'b0);
        run_until_idle(40);
        for (int i = 0; i < 8; i++) pat[i] = acc_at[i];
        chk("t2_accept_cycles", 32'(pat), 32'h93);
        chk("t2_first_beat", 32'(first_beat), 32'd1);
        chk("t2_no_bubble", 32'(last_beat - first_beat + 1), 32'd12);
        chk("t2_count", 32'(beat_count), 32'd12);

        // Backpressure
        do_reset();
        m_axis_tnext = 1'b0;
        src_d.push_back(24'h112233); src_f.push_back(1'b1);
        src_d.push_back(24'h445566); src_f.push_back(1'b0);
        src_d.push_back(24'h778899); src_f.push_back(1'b0);
        hold_err = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_axis_tdata !== 8'h11 || m_axis_tfirst !== 1'b1) hold_err++;
        end
        acc_cnt = 0;
        for (int i = 0; i < 12; i++) acc_cnt += int'(acc_at[i]);
        chk("t3_accepts", 32'(acc_cnt), 32'd2);
        chk("t3_hold", 32'(hold_err), 32'd0);
        chk("t3_snext_full", 32'(s_axis_tnext), 32'd0);
        chk("t3_tvalid", 32'(m_axis_tvalid), 32'd1);
        m_axis_tnext = 1'b1;
        run_until_idle(40);
        chk("t3_beats", 32'(beats_seen), 32'd9);
        chk("t3_count", 32'(beat_count), 32'd9);

        // Reset after the second beat of a word
        do_reset();
        m_axis_tnext = 1'b1;
        src_d.push_back(24'hA1B2C3); src_f.push_back(1'b1);
        k = 0;
        while (beats_seen < 2 && k < 10) begin
            step();
            k++;
        end
        chk("t5_two_beats", 32'(beats_seen), 32'd2);
        rst = 1'b0;
        src_d.push_back(24'h123456); src_f.push_back(1'b1);
        step();
        chk("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t5_count", 32'(beat_count), 32'd0);
        chk("t5_snext", 32'(s_axis_tnext), 32'd0);
        chk("t5_tdata", 32'(m_axis_tdata), 32'd0);
        src_d.delete();
        src_f.delete();
        exp_q.delete();
        rst = 1'b1;
        beats_seen = 0;
        src_d.push_back(24'hDDEEFF); src_f.push_back(1'b1);
        run_until_idle(20);
        chk("t5_beats", 32'(beats_seen), 32'd3);
        chk("t5_count_after", 32'(beat_count), 32'd3);

        // Beat counter wrap
        do_reset();
        quiet = 1'b1;
        data_err = 0;
        m_axis_tnext = 1'b1;
        k = 0;
        for (int i = 0; i < 70000 && beats_seen < 65536; i++) begin
            if (src_d.size() < 2) begin
                src_d.push_back({k[7:0], k[7:0] ^ 8'h5A, ~k[7:0]});
                src_f.push_back(k[0]);
                k++;
            end
            step();
        end
        quiet = 1'b0;
        chk("t6_beats", 32'(beats_seen), 32'd65536);
        chk("t6_wrap", 32'(beat_count), 32'd0);
        chk("t6_data", 32'(data_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
